// File: rtl/bram_axis_reader_if.sv
// Bus bundle for bram_axis_reader: command, native BRAM read port, AXI4-Stream out, status.
// master = the reader itself, slave = the surrounding system.
interface bram_axis_reader_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              sts_valid;
    logic              sts_err;
    logic [LEN_W-1:0]  sts_beats;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, bram_dout, m_axis_tready,
        output cmd_ready, bram_en, bram_addr, m_axis_tdata, m_axis_tvalid,
               m_axis_tlast, sts_valid, sts_err, sts_beats
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, bram_dout, m_axis_tready,
        input  cmd_ready, bram_en, bram_addr, m_axis_tdata, m_axis_tvalid,
               m_axis_tlast, sts_valid, sts_err, sts_beats
    );
endinterface

// File: rtl/bram_axis_reader.sv
// BRAM-to-AXI4-Stream reader: credit-gated reads into a small FIFO, registered stream output.
// Optional stall counter port enabled by defining BRAM_RD_STALL_CNT_EN.
module bram_axis_reader #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 12,
    parameter int LEN_W      = 16,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk_in1,
    input logic                  rst,
    bram_axis_reader_if.master   bus
`ifdef BRAM_RD_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, STATUS} state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    beats_q, beats_d;
    logic                err_q, err_d;
    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:0] last_pipe_q, last_pipe_d;
    logic [PW:0]         fifo_cnt_q, fifo_cnt_d;
    logic [PW:0]         inflight;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                accept, credit, issue, land, out_ld;
    logic                fifo_rd, fifo_wr, bypass;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + (PW+1)'(vld_pipe_q[i]);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        beats_d     = beats_q;
        err_d       = err_q;
        vld_pipe_d  = vld_pipe_q;
        last_pipe_d = last_pipe_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;

        accept  = bus.cmd_valid && cmd_ready_q;
        credit  = (fifo_cnt_q + inflight) < (PW+1)'(FIFO_DEPTH);
        issue   = (state_q == READ) && credit && (issued_q != len_q);
        land    = vld_pipe_q[RD_LATENCY-1];
        out_ld  = !tvalid_q || bus.m_axis_tready;
        fifo_rd = out_ld && (fifo_cnt_q != '0);
        // Landing data skips the FIFO when it is empty so the first beat costs no extra cycle.
        bypass  = out_ld && (fifo_cnt_q == '0) && land;
        fifo_wr = land && !bypass;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = bus.cmd_addr;
                    len_d    = bus.cmd_len;
                    issued_d = '0;
                    beats_d  = bus.cmd_len;
                    err_d    = (bus.cmd_len == '0);
                    state_d  = (bus.cmd_len == '0) ? STATUS : READ;
                end
            end
            READ: begin
                if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (issued_q == len_q - 1'b1)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_pipe_q == '0 && fifo_cnt_q == '0 && !tvalid_q)
                    state_d = STATUS;
            end
            STATUS: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        vld_pipe_d[0]  = issue;
        last_pipe_d[0] = issue && (issued_q == len_q - 1'b1);
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end

        if (fifo_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (fifo_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        fifo_cnt_d = fifo_cnt_q + (PW+1)'(fifo_wr) - (PW+1)'(fifo_rd);

        if (out_ld) begin
            tvalid_d = fifo_rd || bypass;
            tlast_d  = 1'b0;
            if (fifo_rd) begin
                {tlast_d, tdata_d} = fifo_mem[rd_ptr_q];
            end else if (bypass) begin
                tlast_d = last_pipe_q[RD_LATENCY-1];
                tdata_d = bus.bram_dout;
            end
        end

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            beats_q     <= '0;
            err_q       <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            beats_q     <= beats_d;
            err_q       <= err_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
        end
    end

    always_ff @(posedge clk_in1) begin
        if (fifo_wr)
            fifo_mem[wr_ptr_q] <= {last_pipe_q[RD_LATENCY-1], bus.bram_dout};
    end

    fifo_no_overflow: assert property (@(posedge clk_in1) disable iff (rst)
        !(fifo_wr && !fifo_rd && fifo_cnt_q == (PW+1)'(FIFO_DEPTH)));

`ifdef BRAM_RD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (accept)
            stall_cnt_d = '0;
        else if (tvalid_q && !bus.m_axis_tready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_in1) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.bram_en       = issue;
    assign bus.bram_addr     = addr_q;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.sts_valid     = (state_q == STATUS);
    assign bus.sts_err       = err_q;
    assign bus.sts_beats     = beats_q;
endmodule

// File: tb/tb_bram_axis_reader.sv
// Directed bench for bram_axis_reader: 2-cycle BRAM model, negedge monitor, one task per scenario.
module tb_bram_axis_reader;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 16;

    logic clk_in1 = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_in1 = ~clk_in1;

    bram_axis_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bif ();

`ifdef BRAM_RD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    bram_axis_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_in1(clk_in1),
        .rst(rst),
        .bus(bif)
`ifdef BRAM_RD_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // BRAM with two-cycle read latency; mem[i] = i + 0x100
    logic [DATA_W-1:0] mem [1<<ADDR_W];
    logic [DATA_W-1:0] rd1;
    always_ff @(posedge clk_in1) begin
        if (bif.bram_en) rd1 <= mem[bif.bram_addr];
        bif.bram_dout <= rd1;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_iss, n_hs, n_tv, n_stall, n_unstable, max_out, first_tv;
    logic prev_stall;
    logic [DATA_W:0]   prev_beat;
    logic [ADDR_W-1:0] addr_log[$];
    logic [DATA_W:0]   beat_log[$];
    logic [LEN_W:0]    sts_log[$];
    int                sts_cyc[$];
    int                acc_cyc[$];

    initial forever begin
        @(posedge clk_in1);
        cyc++;
    end

    // Sampled on the falling edge: each record describes what the next rising edge commits.
    initial forever begin
        @(negedge clk_in1);
        if (!rst) begin
            if (bif.bram_en) begin
                addr_log.push_back(bif.bram_addr);
                n_iss++;
            end
            if (bif.m_axis_tvalid) begin
                n_tv++;
                if (first_tv < 0) first_tv = cyc;
            end
            if (prev_stall && (!bif.m_axis_tvalid ||
                {bif.m_axis_tlast, bif.m_axis_tdata} !== prev_beat))
                n_unstable++;
            if (bif.m_axis_tvalid && bif.m_axis_tready) begin
                beat_log.push_back({bif.m_axis_tlast, bif.m_axis_tdata});
                n_hs++;
            end
            prev_stall = bif.m_axis_tvalid && !bif.m_axis_tready;
            prev_beat  = {bif.m_axis_tlast, bif.m_axis_tdata};
            if (prev_stall) n_stall++;
            if (n_iss - n_hs > max_out) max_out = n_iss - n_hs;
            if (bif.cmd_valid && bif.cmd_ready) acc_cyc.push_back(cyc + 1);
            if (bif.sts_valid) begin
                sts_log.push_back({bif.sts_err, bif.sts_beats});
                sts_cyc.push_back(cyc);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_mon();
        n_iss = 0; n_hs = 0; n_tv = 0; n_stall = 0; n_unstable = 0; max_out = 0;
        first_tv = -1; prev_stall = 1'b0;
        addr_log.delete(); beat_log.delete(); sts_log.delete();
        sts_cyc.delete(); acc_cyc.delete();
    endtask

    task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        bit ok = 0;
        @(posedge clk_in1); #1;
        bif.cmd_valid = 1'b1;
        bif.cmd_addr  = a;
        bif.cmd_len   = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_in1);
            if (bif.cmd_ready) ok = 1;
        end
        @(posedge clk_in1); #1;
        bif.cmd_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cmd_accept timeout addr=%0h len=%0d", a, l);
        end
    endtask

    task automatic wait_sts(input int n);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk_in1); #1;
            if (sts_log.size() >= n) ok = 1;
        end
        repeat (2) @(posedge clk_in1);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sts_wait timeout got %0d strobes need %0d", sts_log.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_in1);
        @(negedge clk_in1);
        checks++; if (bif.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", bif.cmd_ready); end
        checks++; if (bif.bram_en !== 1'b0) begin errors++; $display("FAIL rst_bram_en got %b exp 0", bif.bram_en); end
        checks++; if (bif.bram_addr !== '0) begin errors++; $display("FAIL rst_bram_addr got %0h exp 0", bif.bram_addr); end
        checks++; if (bif.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", bif.m_axis_tvalid); end
        checks++; if (bif.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", bif.m_axis_tlast); end
        checks++; if (bif.m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %0h exp 0", bif.m_axis_tdata); end
        checks++; if (bif.sts_valid !== 1'b0 || bif.sts_err !== 1'b0 || bif.sts_beats !== '0) begin
            errors++; $display("FAIL rst_sts got v=%b e=%b b=%0d exp 0/0/0", bif.sts_valid, bif.sts_err, bif.sts_beats);
        end
`ifdef BRAM_RD_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
`endif
        @(posedge clk_in1); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [LEN_W:0] exp_sts;
        clear_mon();
        bif.m_axis_tready = 1'b1;
        send_cmd(12'h004, 16'd8);
        wait_sts(1);
        checks++; if (beat_log.size() != 8) begin errors++; $display("FAIL basic_count got %0d exp 8", beat_log.size()); end
        for (int i = 0; i < 8 && i < beat_log.size(); i++) begin
            logic [DATA_W:0] exp_b;
            exp_b = {(i == 7), 64'h104 + 64'(i)};
            checks++;
            if (beat_log[i] !== exp_b) begin errors++; $display("FAIL basic_beat%0d got %0h exp %0h", i, beat_log[i], exp_b); end
        end
        checks++; if (acc_cyc.size() != 1 || first_tv - acc_cyc[0] != 3) begin
            errors++; $display("FAIL basic_latency got %0d exp 3", first_tv - (acc_cyc.size() > 0 ? acc_cyc[0] : 0));
        end
        exp_sts = {1'b0, 16'd8};
        checks++; if (sts_log.size() != 1 || sts_log[0] !== exp_sts) begin
            errors++; $display("FAIL basic_sts got n=%0d v=%0h exp n=1 v=%0h", sts_log.size(), sts_log.size() > 0 ? sts_log[0] : '0, exp_sts);
        end
        checks++; if (n_tv != 8) begin errors++; $display("FAIL basic_sustained got %0d valid cycles exp 8", n_tv); end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        bit done = 0;
        clear_mon();
        bif.m_axis_tready = 1'b1;
        send_cmd(12'h004, 16'd8);
        for (int k = 0; k < 400 && !done; k++) begin
            @(posedge clk_in1); #1;
            bif.m_axis_tready = pat[k % 4];
            if (sts_log.size() > 0) done = 1;
        end
        bif.m_axis_tready = 1'b1;
        repeat (2) @(posedge clk_in1);
        checks++; if (!done) begin errors++; $display("FAIL bp_sts timeout"); end
        checks++; if (beat_log.size() != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", beat_log.size()); end
        for (int i = 0; i < 8 && i < beat_log.size(); i++) begin
            logic [DATA_W:0] exp_b;
            exp_b = {(i == 7), 64'h104 + 64'(i)};
            checks++;
            if (beat_log[i] !== exp_b) begin errors++; $display("FAIL bp_beat%0d got %0h exp %0h", i, beat_log[i], exp_b); end
        end
        checks++; if (n_unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", n_unstable); end
        checks++; if (max_out > 5) begin errors++; $display("FAIL bp_outstanding got %0d exp <=5", max_out); end
        checks++; if (n_stall == 0) begin errors++; $display("FAIL bp_stalls got 0 exp >0"); end
`ifdef BRAM_RD_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'(n_stall)) begin errors++; $display("FAIL bp_stall_cnt got %0d exp %0d", stall_cnt, n_stall); end
`endif
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_a [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        logic [DATA_W-1:0] exp_d [4] = '{64'h10FE, 64'h10FF, 64'h100, 64'h101};
        clear_mon();
        bif.m_axis_tready = 1'b1;
        send_cmd(12'hFFE, 16'd4);
        wait_sts(1);
        checks++; if (addr_log.size() != 4 || beat_log.size() != 4) begin
            errors++; $display("FAIL wrap_count got %0d reads %0d beats exp 4/4", addr_log.size(), beat_log.size());
        end
        for (int i = 0; i < 4 && i < addr_log.size() && i < beat_log.size(); i++) begin
            checks++;
            if (addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d got %0h exp %0h", i, addr_log[i], exp_a[i]); end
            checks++;
            if (beat_log[i] !== {(i == 3), exp_d[i]}) begin
                errors++; $display("FAIL wrap_beat%0d got %0h exp %0h", i, beat_log[i], {(i == 3), exp_d[i]});
            end
        end
    endtask

    task automatic test_zero_len();
        logic [LEN_W:0] exp_sts = {1'b1, 16'd0};
        clear_mon();
        send_cmd(12'h010, 16'd0);
        wait_sts(1);
        checks++; if (n_iss != 0 || n_tv != 0) begin errors++; $display("FAIL zero_activity got reads=%0d valid=%0d exp 0/0", n_iss, n_tv); end
        checks++; if (sts_log.size() != 1 || sts_log[0] !== exp_sts) begin
            errors++; $display("FAIL zero_sts got n=%0d v=%0h exp n=1 v=%0h", sts_log.size(), sts_log.size() > 0 ? sts_log[0] : '0, exp_sts);
        end
        // status is high in the first cycle after the accepting edge
        checks++; if (sts_cyc.size() != 1 || acc_cyc.size() != 1 || sts_cyc[0] != acc_cyc[0]) begin
            errors++; $display("FAIL zero_sts_timing got sts=%0d acc=%0d exp equal",
                sts_cyc.size() > 0 ? sts_cyc[0] : -1, acc_cyc.size() > 0 ? acc_cyc[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 0;
        logic [LEN_W:0] exp_sts = {1'b0, 16'd2};
        clear_mon();
        bif.m_axis_tready = 1'b1;
        send_cmd(12'h000, 16'd100);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk_in1); #1;
            if (n_hs >= 10) ok = 1;
        end
        rst = 1'b1;
        @(posedge clk_in1);
        @(negedge clk_in1);
        checks++; if (!ok) begin errors++; $display("FAIL mid_progress got %0d beats exp 10", n_hs); end
        checks++; if (bif.m_axis_tvalid !== 1'b0 || bif.m_axis_tlast !== 1'b0 || bif.m_axis_tdata !== '0) begin
            errors++; $display("FAIL mid_rst_stream got v=%b l=%b d=%0h exp 0/0/0", bif.m_axis_tvalid, bif.m_axis_tlast, bif.m_axis_tdata);
        end
        checks++; if (bif.bram_en !== 1'b0 || bif.bram_addr !== '0 || bif.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ctrl got en=%b a=%0h rdy=%b exp 0/0/0", bif.bram_en, bif.bram_addr, bif.cmd_ready);
        end
        checks++; if (bif.sts_valid !== 1'b0 || bif.sts_beats !== '0 || bif.sts_err !== 1'b0) begin
            errors++; $display("FAIL mid_rst_sts got v=%b b=%0d exp 0/0", bif.sts_valid, bif.sts_beats);
        end
        checks++; if (sts_log.size() != 0) begin errors++; $display("FAIL mid_no_sts got %0d strobes exp 0", sts_log.size()); end
        @(posedge clk_in1); #1;
        rst = 1'b0;
        clear_mon();
        send_cmd(12'h000, 16'd2);
        wait_sts(1);
        checks++; if (beat_log.size() != 2) begin errors++; $display("FAIL mid_after_count got %0d exp 2", beat_log.size()); end
        else begin
            checks++; if (beat_log[0] !== {1'b0, 64'h100}) begin errors++; $display("FAIL mid_after_beat0 got %0h exp %0h", beat_log[0], {1'b0, 64'h100}); end
            checks++; if (beat_log[1] !== {1'b1, 64'h101}) begin errors++; $display("FAIL mid_after_beat1 got %0h exp %0h", beat_log[1], {1'b1, 64'h101}); end
        end
        checks++; if (sts_log.size() != 1 || sts_log[0] !== exp_sts) begin
            errors++; $display("FAIL mid_after_sts got n=%0d exp n=1 v=%0h", sts_log.size(), exp_sts);
        end
    endtask

    task automatic test_back_to_back();
        int n_acc = 0;
        clear_mon();
        bif.m_axis_tready = 1'b1;
        @(posedge clk_in1); #1;
        bif.cmd_valid = 1'b1;
        bif.cmd_addr  = 12'h002;
        bif.cmd_len   = 16'd1;
        for (int i = 0; i < 100 && n_acc < 2; i++) begin
            @(negedge clk_in1);
            if (bif.cmd_ready) begin
                n_acc++;
                @(posedge clk_in1); #1;
                bif.cmd_addr = 12'h005;
                if (n_acc == 2) bif.cmd_valid = 1'b0;
            end
        end
        bif.cmd_valid = 1'b0;
        wait_sts(2);
        checks++; if (n_acc != 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", n_acc); end
        checks++; if (beat_log.size() != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", beat_log.size()); end
        else begin
            checks++; if (beat_log[0] !== {1'b1, 64'h102}) begin errors++; $display("FAIL b2b_beat0 got %0h exp %0h", beat_log[0], {1'b1, 64'h102}); end
            checks++; if (beat_log[1] !== {1'b1, 64'h105}) begin errors++; $display("FAIL b2b_beat1 got %0h exp %0h", beat_log[1], {1'b1, 64'h105}); end
        end
        // second accept lands on the edge ending the cycle after the first strobe
        checks++; if (acc_cyc.size() != 2 || sts_cyc.size() != 2 || acc_cyc[1] != sts_cyc[0] + 2) begin
            errors++; $display("FAIL b2b_order got acc2=%0d sts1=%0d exp acc2=sts1+2",
                acc_cyc.size() > 1 ? acc_cyc[1] : -1, sts_cyc.size() > 0 ? sts_cyc[0] : -1);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 64'(i) + 64'h100;
        bif.cmd_valid     = 1'b0;
        bif.cmd_addr      = '0;
        bif.cmd_len       = '0;
        bif.m_axis_tready = 1'b1;
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1);
    end
endmodule

// File: doc/bram_axis_reader.md
Name: bram_axis_reader

Overview:
- Memory-to-stream reader; the counterpart of the stream-to-BRAM write path in the datamover BRAM subsystem.
- Accepts a command of start address and beat count, then reads consecutive words from a native BRAM port with fixed read latency.
- Emits the words as an AXI4-Stream packet with full tready backpressure and tlast on the final beat.
- Reports completion on a one-cycle status strobe.

Parameters:
- DATA_W, 64, BRAM word and tdata width in bits.
- ADDR_W, 12, BRAM word-address width; the address space is 2^ADDR_W words.
- LEN_W, 16, width of the command beat count.
- RD_LATENCY, 2, BRAM read latency in cycles, from bram_en to valid bram_dout. Legal values: 1 or 2.
- FIFO_DEPTH, 4, output buffer depth in words. Must be at least RD_LATENCY+2 and a power of two.

Ports:
- clk_in1  in  1  Sole clock; everything is synchronous to its rising edge.
- rst  in  1  Synchronous, active-high reset.
- cmd_valid  in  1  Command valid.
- cmd_ready  out  1  Command accepted on cmd_valid&&cmd_ready.
- cmd_addr  in  ADDR_W  Start word address.
- cmd_len  in  LEN_W  Number of beats to read.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_W  BRAM read address.
- bram_dout  in  DATA_W  BRAM read data, valid RD_LATENCY cycles after bram_en.
- m_axis_tdata  out  DATA_W  Stream data.
- m_axis_tvalid  out  1  Stream valid.
- m_axis_tready  in  1  Stream ready.
- m_axis_tlast  out  1  Asserted on the last beat of a command.
- sts_valid  out  1  One-cycle completion strobe.
- sts_err  out  1  Qualified by sts_valid; set when cmd_len was 0.
- sts_beats  out  LEN_W  Qualified by sts_valid; number of beats transferred.

Behaviour:
- Reset values: cmd_ready=0, bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, sts_valid=0, sts_err=0, sts_beats=0. The FIFO is emptied, all counters are cleared and the FSM returns to IDLE.
- Reset mid-transfer: the packet is abandoned with no tlast and no status; the next command starts cleanly.
- FSM IDLE:
  - cmd_ready=1.
  - On accept, latch the address and length.
  - If len=0, go to STATUS with err=1 and beats=0.
  - Otherwise go to READ.
- FSM READ:
  - Each cycle, assert bram_en when the credit condition holds: (FIFO occupancy + reads in flight) < FIFO_DEPTH and reads remain.
  - bram_addr increments by 1 per issued read and wraps from 2^ADDR_W-1 to 0 with no error.
  - When the last read has been issued, go to DRAIN.
- FSM DRAIN: wait until all in-flight reads have landed and the FIFO is empty (final beat handshaken), then go to STATUS.
- FSM STATUS:
  - sts_valid=1 for exactly one cycle, with sts_beats equal to the accepted beat count.
  - Return to IDLE; cmd_ready reasserts the following cycle.
- Read pipeline:
  - A shift register of RD_LATENCY valid bits tracks reads in flight.
  - bram_dout is written into the FIFO in the cycle its valid bit emerges.
  - The credit rule guarantees the FIFO never overflows. Overflow is a design error, flagged by a simulation assertion.
- Stream output:
  - Comes from the FIFO head, registered.
  - tvalid stays high until handshake; tdata and tlast are held stable while tvalid&&!tready.
  - tlast is tagged on the FIFO entry whose read index equals len-1.
- Throughput: with tready held at 1, one beat per cycle sustained after an initial latency of RD_LATENCY+1 cycles from the command accept to the first tvalid.
- Simultaneous FIFO write and read when full or empty: both proceed and occupancy is unchanged.
- Only one command is outstanding at a time; cmd_ready=0 outside IDLE.

Optional Feature:
- Macro: BRAM_RD_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt (out, 32 bits).
  - It counts cycles with m_axis_tvalid&&!m_axis_tready.
  - Saturates at 0xFFFFFFFF.
  - Clears on rst and on each command accept.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic read: preload BRAM[i]=i+0x100 for i=0..15; command addr=4, len=8; tready=1 -> 8 consecutive beats with tdata 0x104..0x10B; tlast only on 0x10B; first tvalid 3 cycles after accept (RD_LATENCY=2); sts_valid with beats=8, err=0.
- Backpressure: same command with tready toggling 1,0,0,1 repeating -> no lost or duplicated beats; tdata stable while stalled; bram_en never drives the FIFO past 4 entries. With BRAM_RD_STALL_CNT_EN defined, stall_cnt equals the number of stalled valid cycles.
- Wrap-around: ADDR_W=12, command addr=0xFFE, len=4 -> reads 0xFFE, 0xFFF, 0x000, 0x001 in order; tlast on the 4th beat.
- Zero length: command len=0 -> no bram_en and no tvalid; sts_valid one cycle later with err=1, beats=0.
- Reset mid-operation: command len=100; assert rst after 10 beats with tready=1 -> all outputs return to reset values the next cycle; no sts_valid. A following command addr=0, len=2 completes normally.
- Back-to-back commands: cmd_valid held high with two queued commands (len=1 each) -> the second is accepted only after the first's sts_valid; each packet is a single beat with tlast=1.
